// File: rtl/imem_loader.sv
// Instruction memory loader: assembles a checksummed little-endian byte stream into 32-bit
// words, writes them to instruction memory and holds the CPU until the image verifies.
module imem_loader #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           MAX_WORDS  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  start,
    output logic                  im_we,
    output logic [ADDR_WIDTH-1:0] im_addr,
    output logic [31:0]           im_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           word_count
);

    typedef enum logic [2:0] {
        StIdle,
        StHdr,
        StData,
        StCsum,
        StDone,
        StErr
    } state_e;

    state_e      state_q;
    logic [1:0]  byte_cnt_q;
    logic [31:0] hdr_q;
    logic [31:0] word_q;
    logic [7:0]  csum_q;

    logic        accept;
    logic [7:0]  csum_nxt;
    logic [31:0] hdr_nxt;
    logic [31:0] word_nxt;
    logic        last_word;

    always_comb begin
        accept    = in_valid && in_ready;
        csum_nxt  = csum_q ^ in_data;
        // Bytes enter at the top and shift down, so byte 0 lands in [7:0] after four.
        hdr_nxt   = {in_data, hdr_q[31:8]};
        word_nxt  = {in_data, word_q[31:8]};
        last_word = ({16'd0, word_count} + 32'd1) == hdr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            byte_cnt_q <= 2'd0;
            hdr_q      <= '0;
            word_q     <= '0;
            csum_q     <= '0;
            in_ready   <= 1'b0;
            im_we      <= 1'b0;
            im_addr    <= BASE_ADDR;
            im_wdata   <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
        end else begin
            im_we <= 1'b0;
            case (state_q)
                StIdle: begin
                    state_q  <= StHdr;
                    in_ready <= 1'b1;
                end
                StHdr: begin
                    if (accept) begin
                        hdr_q      <= hdr_nxt;
                        csum_q     <= csum_nxt;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            if (hdr_nxt > MAX_WORDS) begin
                                state_q  <= StErr;
                                in_ready <= 1'b0;
                                error    <= 1'b1;
                            end else if (hdr_nxt == '0) begin
                                state_q <= StCsum;
                            end else begin
                                state_q <= StData;
                            end
                        end
                    end
                end
                StData: begin
                    if (accept) begin
                        word_q     <= word_nxt;
                        csum_q     <= csum_nxt;
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            im_we      <= 1'b1;
                            im_addr    <= BASE_ADDR + ADDR_WIDTH'({word_count, 2'b00});
                            im_wdata   <= word_nxt;
                            word_count <= word_count + 16'd1;
                            if (last_word) begin
                                state_q <= StCsum;
                            end
                        end
                    end
                end
                StCsum: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (in_data == csum_q) begin
                            state_q  <= StDone;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state_q <= StErr;
                            error   <= 1'b1;
                        end
                    end
                end
                StDone, StErr: begin
                    if (start) begin
                        state_q    <= StHdr;
                        in_ready   <= 1'b1;
                        cpu_hold   <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        word_count <= '0;
                        csum_q     <= '0;
                        byte_cnt_q <= 2'd0;
                        hdr_q      <= '0;
                        word_q     <= '0;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
